// File: rtl/hazard_ctrl_ms_pkg.sv
// Shared types for the multi-cycle hazard / pipeline-control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_ctrl_ms_pkg;

    // PC source select driven into the fetch stage.
    typedef enum logic [1:0] {
        PCSEL_SEQ = 2'd0,
        PCSEL_ADD = 2'd1,
        PCSEL_ALU = 2'd2
    } pcsel_e;

    // RUN: no hazard pending. LU_WAIT: extra load-use bubbles still owed.
    typedef enum logic {
        RUN     = 1'b0,
        LU_WAIT = 1'b1
    } hz_state_e;

    // Single-bit pipeline status seen by the hazard unit.
    typedef struct packed {
        logic fsm_run;
        logic ex_mem_read;
        logic id_use_rs1;
        logic id_use_rs2;
        logic mem_jump;
        logic mem_branch;
        logic mem_branch_taken;
        logic mem_add_to_pc;
        logic mem_access;
        logic dmem_ready;
    } hz_ctrl_i_t;

    // Register enables, bubble muxes and PC select driven by the hazard unit.
    typedef struct packed {
        logic   en_pc;
        logic   en_ifid;
        logic   en_idex;
        logic   en_exmem;
        logic   flush_ifid;
        logic   nop_idex;
        logic   nop_exmem;
        pcsel_e pc_sel;
    } hz_ctrl_o_t;

endpackage

// File: rtl/hazard_ctrl_ms_if.sv
// Bundle between the pipeline datapath (master) and the hazard unit (slave).
// Latency: wires only.
// Backpressure: none; control travels back combinationally on ctrl_o.
interface hazard_ctrl_ms_if #(
    parameter int REG_AW = 5
);
    import hazard_ctrl_ms_pkg::*;

    hz_ctrl_i_t        ctrl_i;
    logic [REG_AW-1:0] ex_rd;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    hz_ctrl_o_t        ctrl_o;

    modport master (output ctrl_i, ex_rd, id_rs1, id_rs2, input ctrl_o);
    modport slave  (input ctrl_i, ex_rd, id_rs1, id_rs2, output ctrl_o);

endinterface

// File: rtl/hazard_ctrl_ms_perf_cnt.sv
// Wrapping event counter used for the hazard unit performance statistics.
// Latency: count reflects an event on the edge after it is flagged.
// Backpressure: none; wraps modulo 2^CNT_W.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    // Synchronous clear, otherwise count one per enabled cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl_ms.sv
// Load-use stall, branch/jump redirect and dmem freeze control for the 5-stage core.
// Latency: control outputs combinational in the same cycle; counters one edge later.
// Backpressure: dmem not ready freezes every pipeline register; !fsm_run holds all state.
module hazard_ctrl_ms
    import hazard_ctrl_ms_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LU_STALL = 1,
    parameter int CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_ctrl_ms_if.slave    hz,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic [CNT_W-1:0]   freeze_cnt
);

    if (LU_STALL < 1 || LU_STALL > 7) begin : g_bad_lu_stall
        $error("hazard_ctrl_ms: LU_STALL must lie in 1..7");
    end

    localparam hz_ctrl_o_t CTRL_RESET  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, PCSEL_SEQ};
    localparam hz_ctrl_o_t CTRL_HOLD   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, PCSEL_SEQ};
    localparam hz_ctrl_o_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, PCSEL_SEQ};
    localparam hz_ctrl_o_t CTRL_STALL  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, PCSEL_SEQ};
    localparam hz_ctrl_o_t CTRL_NORMAL = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, PCSEL_SEQ};
    localparam logic [2:0] LU_RELOAD   = 3'(LU_STALL - 1);

    hz_state_e  state, state_nxt;
    logic [2:0] lu_cnt, lu_cnt_nxt;
    hz_ctrl_o_t ctrl;
    logic       redirect, lu_hit, freeze;
    logic       stall_ev, flush_ev, freeze_ev;

    assign redirect = hz.ctrl_i.mem_jump | (hz.ctrl_i.mem_branch & hz.ctrl_i.mem_branch_taken);
    assign freeze   = hz.ctrl_i.mem_access & ~hz.ctrl_i.dmem_ready;
    assign lu_hit   = hz.ctrl_i.ex_mem_read && (hz.ex_rd != '0) &&
                      ((hz.ctrl_i.id_use_rs1 && (hz.ex_rd == hz.id_rs1)) ||
                       (hz.ctrl_i.id_use_rs2 && (hz.ex_rd == hz.id_rs2)));
    assign hz.ctrl_o = ctrl;

    // State and bubble down-counter; reset abandons any pending stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= RUN;
            lu_cnt <= '0;
        end else begin
            state  <= state_nxt;
            lu_cnt <= lu_cnt_nxt;
        end
    end

    // Prioritised control decode: reset, halt, freeze, redirect, load-use, normal.
    always_comb begin
        state_nxt  = state;
        lu_cnt_nxt = lu_cnt;
        ctrl       = CTRL_NORMAL;
        stall_ev   = 1'b0;
        flush_ev   = 1'b0;
        freeze_ev  = 1'b0;
        if (!rst_n) begin
            ctrl       = CTRL_RESET;
            state_nxt  = RUN;
            lu_cnt_nxt = '0;
        end else if (!hz.ctrl_i.fsm_run) begin
            ctrl = CTRL_HOLD;
        end else if (freeze) begin
            ctrl      = CTRL_HOLD;
            freeze_ev = 1'b1;
        end else if (redirect) begin
            ctrl        = CTRL_FLUSH;
            ctrl.pc_sel = hz.ctrl_i.mem_add_to_pc ? PCSEL_ADD : PCSEL_ALU;
            state_nxt   = RUN;
            lu_cnt_nxt  = '0;
            flush_ev    = 1'b1;
        end else if (lu_hit || state == LU_WAIT) begin
            ctrl     = CTRL_STALL;
            stall_ev = 1'b1;
            if (state == LU_WAIT) begin
                lu_cnt_nxt = lu_cnt - 3'd1;
                if (lu_cnt == 3'd1) begin
                    state_nxt = RUN;
                end
            end else if (LU_STALL > 1) begin
                state_nxt  = LU_WAIT;
                lu_cnt_nxt = LU_RELOAD;
            end
        end
    end

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst_n(rst_n), .en(stall_ev), .cnt(stall_cnt)
    );
    hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk(clk), .rst_n(rst_n), .en(flush_ev), .cnt(flush_cnt)
    );
    hazard_perf_cnt #(.CNT_W(CNT_W)) u_freeze_cnt (
        .clk(clk), .rst_n(rst_n), .en(freeze_ev), .cnt(freeze_cnt)
    );

endmodule
